// File: rtl/riscv_v_rf_wr_arbiter.sv
// riscv_v_rf_wr_arbiter
//   Arbitrates NUM_REQ execution units onto the single vector register-file
//   write port. Grants round-robin when idle and locks onto one requester
//   for the length of a multi-beat (LMUL) burst. Bursts longer than
//   MAX_BEATS are cut off and flagged on err_burst.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           pipeline flush: drops the write and any burst lock
//   wr_stall        register-file write port busy: everything holds
//   req_valid/last  per-requester beat valid / last beat of burst
//   req_addr/data   packed per-requester address / data, requester i at slice i
//   req_ready       per-requester accept (combinational, one-hot or zero)
//   wr_en/addr/data/src  registered register-file write, one cycle after accept
//   err_burst       one-cycle pulse after a forced burst release
module riscv_v_rf_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_BEATS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    wr_src,
  output logic                          err_burst
);

  localparam int unsigned SRC_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  rr_ptr;
  logic [BEAT_W-1:0] beat_cnt;

  logic              grant_vld;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  cand;
  logic              grant_last;
  logic              burst_full;

  // Successor index modulo NUM_REQ.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : SRC_W'(32'(i) + 1);
  endfunction

  // Grant selection: owner only while locked, else first valid from rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state == LOCKED) begin
      grant_vld = req_valid[owner];
      grant_idx = owner;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = SRC_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    // Nothing is accepted while the write path cannot advance.
    if (rst || flush || wr_stall) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_last = req_last[grant_idx];
  assign burst_full = (beat_cnt == BEAT_W'(MAX_BEATS - 1));

  // State, burst tracking and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_src    <= '0;
      err_burst <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_en     <= 1'b0;
      err_burst <= 1'b0;
    end else if (wr_stall) begin
      err_burst <= 1'b0;
    end else begin
      err_burst <= 1'b0;
      if (grant_vld) begin
        wr_en   <= 1'b1;
        wr_addr <= req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        wr_data <= req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        wr_src  <= grant_idx;
        if (state == IDLE) begin
          if (grant_last) begin
            rr_ptr <= next_idx(grant_idx);
          end else begin
            state    <= LOCKED;
            owner    <= grant_idx;
            beat_cnt <= BEAT_W'(1);
          end
        end else begin
          if (grant_last || burst_full) begin
            // Normal end of burst, or burst cut off at MAX_BEATS.
            state     <= IDLE;
            rr_ptr    <= next_idx(owner);
            beat_cnt  <= '0;
            err_burst <= !grant_last;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/riscv_v_rf_wr_arbiter.md
RISCV_V_RF_WR_ARBITER -- requirements
Module: riscv_v_rf_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requesting execution units (ALU, MUL, LSU); legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register-file address width (RISCV_V_RF_ADDR_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 128: write data width.
REQ-004 SHALL have parameter MAX_BEATS, default 8: maximum beats per locked burst (LMUL group).
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port flush, input, 1: pipeline flush.
REQ-008 SHALL have port wr_stall, input, 1: register-file write port busy.
REQ-009 SHALL have port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-010 SHALL have port req_last, input, NUM_REQ: per-requester last beat of burst.
REQ-011 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH: packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: packed data, same packing.
REQ-013 SHALL have port req_ready, output, NUM_REQ: per-requester accept, combinational.
REQ-014 SHALL have ports wr_en (1), wr_addr (ADDR_WIDTH), wr_data (DATA_WIDTH), wr_src ($clog2(NUM_REQ)), all outputs: registered write to the register file.
REQ-015 SHALL have port err_burst, output, 1: one-cycle pulse on forced burst release.

Function
REQ-016 Beat accepted for requester i when req_valid[i] & req_ready[i]; beat appears on wr_* exactly one cycle later (latency 1).
REQ-017 At most one req_ready bit high per cycle; req_ready[i] high only if req_valid[i] high.
REQ-018 All req_ready SHALL be 0 while rst, flush or wr_stall is high.
REQ-019 States: IDLE, LOCKED; state register plus owner index, round-robin pointer rr_ptr and beat counter beat_cnt.
REQ-020 IDLE: grant first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-021 IDLE accept with req_last=1: stay IDLE, rr_ptr <= granted+1 mod NUM_REQ.
REQ-022 IDLE accept with req_last=0: go LOCKED, owner <= granted, beat_cnt <= 1.
REQ-023 LOCKED: only owner eligible; other requesters get req_ready=0 even if owner not valid.
REQ-024 LOCKED accept with req_last=1: go IDLE, rr_ptr <= owner+1 mod NUM_REQ, beat_cnt <= 0.
REQ-025 LOCKED accept with req_last=0 and beat_cnt = MAX_BEATS-1: forced release as REQ-024 and err_burst=1 the following cycle; otherwise beat_cnt increments.
REQ-026 wr_stall high: wr_en, wr_addr, wr_data, wr_src, state, owner, rr_ptr, beat_cnt all hold.
REQ-027 wr_stall low, no accept: wr_en <= 0; wr_addr/wr_data/wr_src hold.
REQ-028 wr_stall low, accept: wr_en <= 1, wr_addr/wr_data <= granted slice, wr_src <= granted index.
REQ-029 flush (rst low): wr_en <= 0, state <= IDLE, beat_cnt <= 0, rr_ptr holds, err_burst <= 0; flush takes priority over wr_stall.
REQ-030 Priority: rst > flush > wr_stall > normal operation.
REQ-031 err_burst SHALL be 0 in every cycle not immediately following a forced release.

Reset
REQ-032 On rst: wr_en=0, wr_addr=0, wr_data=0, wr_src=0, err_burst=0, state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, effective next edge, regardless of stall/flush/burst in progress.

Verification
REQ-033 Reset, then req_valid=3'b111, all last=1, no stall -> grants 0,1,2,0 on consecutive cycles; wr_en=1 from cycle 2 with wr_src 0,1,2,0.
REQ-034 Requester 1 sends 4-beat burst (last on beat 4) while 0 and 2 valid -> wr_src=1 for 4 consecutive writes, then requester 2 granted.
REQ-035 Accept beat addr=5'd7, then wr_stall=1 for 3 cycles -> wr_en=1, wr_addr=7 held 3 cycles, req_ready=0 throughout, no beat lost.
REQ-036 Requester 0 sends 8 beats with last=0 (MAX_BEATS=8) -> after 8th accept, IDLE, err_burst=1 for one cycle, next grant goes to requester 1.
REQ-037 Flush mid-burst (LOCKED, owner=2) -> next cycle wr_en=0, state IDLE, any valid requester grantable, rr_ptr unchanged.
REQ-038 rst asserted together with flush and wr_stall during LOCKED -> all outputs and state at reset values next cycle.
